// File: rtl/alu_serial.sv
// alu_serial: digit-serial ALU. WIDTH-bit operands are processed DIGIT bits per
// clock, least significant slice first, with a carry register chaining slices.
// Every operation is X + Y + cin (arithmetic) or X ^ Y (logic), where X, Y and
// cin are selected from A, B and the 4-bit {mode,opcode} when start is accepted.
// A start/busy/done handshake frames each operation. Result and flags are
// visible only from the done pulse on, and are held until the next one.
module alu_serial #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [1:0]       opcode,
   input  logic [WIDTH-1:0] ain,
   input  logic [WIDTH-1:0] bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             err
);

   localparam int            NSLICE = WIDTH / DIGIT;
   localparam int            CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST   = CW'(NSLICE - 1);

   // The slicing only makes sense if the operand splits into whole digits.
   if (WIDTH % DIGIT != 0) begin : g_width_check
      $error("alu_serial: WIDTH must be a multiple of DIGIT");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t state, state_nx;

   // Operation decode, valid only while a start is being accepted.
   logic [WIDTH-1:0] dec_x, dec_y;
   logic             dec_cin, dec_logic, dec_illegal;
   logic             accept;

   // Working registers for the operation in flight.
   logic [WIDTH-1:0] x_q, y_q, acc;
   logic [CW-1:0]    cnt;
   logic             carry_q, logic_q, illegal_q, ovf_q;

   // Current slice arithmetic.
   logic [DIGIT-1:0] x_sl, y_sl, s_sl;
   logic [DIGIT:0]   sum_ext;
   logic             c_msb_in;

   // A start is taken only in IDLE once the previous done pulse has gone.
   assign accept = (state == S_IDLE) && start && !done;

   // Map {mode,opcode} onto the X, Y, cin operands of the common adder form.
   always_comb begin
      // NOTE: every combinational output gets a default before the case, so no
      // path leaves a signal unassigned and no latch is inferred.
      dec_x       = ain;
      dec_y       = '0;
      dec_cin     = 1'b0;
      dec_logic   = 1'b0;
      dec_illegal = 1'b0;
      case ({mode, opcode})
         4'b0000: dec_logic = 1'b1;                                   // A
         4'b0001: begin dec_x = ~ain; dec_logic = 1'b1; end           // ~A
         4'b0010: begin dec_y = bin;  dec_logic = 1'b1; end           // A^B
         4'b0011: begin                                               // ~(A^B)
            dec_x     = ~ain;
            dec_y     = bin;
            dec_logic = 1'b1;
         end
         4'b0100: ;                                                   // A
         4'b0101: dec_x = ~ain;                                       // ~A
         4'b0110: dec_y = bin;                                        // A+B
         4'b0111: begin dec_y = ~bin; dec_cin = 1'b1; end             // A-B
         4'b1000: dec_cin = 1'b1;                                     // A+1
         4'b1001: begin dec_x = ~ain; dec_cin = 1'b1; end             // -A
         4'b1010: begin dec_y = bin;  dec_cin = 1'b1; end             // A+B+1
         4'b1011: begin                                               // B-A
            dec_x   = ~ain;
            dec_y   = bin;
            dec_cin = 1'b1;
         end
         default: begin
            dec_x       = '0;
            dec_illegal = 1'b1;
         end
      endcase
   end

   // One digit of the adder (or XOR for logic ops) on the slice selected by cnt.
   always_comb begin
      x_sl     = x_q[cnt*DIGIT +: DIGIT];
      y_sl     = y_q[cnt*DIGIT +: DIGIT];
      sum_ext  = {1'b0, x_sl} + {1'b0, y_sl} + {{DIGIT{1'b0}}, carry_q};
      s_sl     = logic_q ? (x_sl ^ y_sl) : sum_ext[DIGIT-1:0];
      // Carry into the top bit of this slice; only meaningful on the last slice.
      c_msb_in = sum_ext[DIGIT-1] ^ x_sl[DIGIT-1] ^ y_sl[DIGIT-1];
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (accept) state_nx = dec_illegal ? S_DONE : S_RUN;
         S_RUN:  if (cnt == LAST) state_nx = S_DONE;
         S_DONE: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      busy = (state != S_IDLE) || done;
   end

   // Operand and partial-result storage.
   always_ff @(posedge clk) begin
      // NOTE: these datapath registers have no reset; they are always loaded on
      // an accepted start before they are read, and nothing visible depends on
      // them otherwise.
      if (accept) begin
         x_q <= dec_x;
         y_q <= dec_y;
         acc <= '0;
      end else if (state == S_RUN) begin
         acc[cnt*DIGIT +: DIGIT] <= s_sl;
      end
   end

   // Slice sequencing: carry chain, slice counter and operation class.
   always_ff @(posedge clk) begin
      if (reset) begin
         carry_q   <= 1'b0;
         cnt       <= '0;
         logic_q   <= 1'b0;
         illegal_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else if (accept) begin
         carry_q   <= dec_cin;
         cnt       <= '0;
         logic_q   <= dec_logic | dec_illegal;
         illegal_q <= dec_illegal;
         ovf_q     <= 1'b0;
      end else if (state == S_RUN) begin
         if (!logic_q) carry_q <= sum_ext[DIGIT];
         if (cnt == LAST) ovf_q <= ~logic_q & (c_msb_in ^ sum_ext[DIGIT]);
         cnt <= cnt + CW'(1);
      end
   end

   // Visible result and flags, published together with the done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         done   <= 1'b0;
         result <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
         zero   <= 1'b0;
         err    <= 1'b0;
      end else begin
         done <= (state == S_DONE);
         if (accept && !dec_illegal) err <= 1'b0;
         if (state == S_DONE) begin
            result <= acc;
            cout   <= ~logic_q & carry_q;
            ovf    <= ovf_q;
            zero   <= (acc == '0);
            err    <= illegal_q;
         end
      end
   end

endmodule
